// File: rtl/sram_req_port_if.sv
// rtl/sram_req_port_if.sv - client handshake and SRAM local-bus signal bundle
// Purpose: groups the request/response handshake and the icoboard_sram bus.
// Ports (signals):
//   req_valid/req_ready/req_write/req_addr/req_wdata/req_be  request channel
//   rsp_valid/rsp_ready/rsp_rdata                            response channel
//   address/write_enable/write_data/lower_byte/upper_byte    to SRAM controller
//   read_data                                                from SRAM controller
// Modports: slave = the request port block, master = client plus SRAM side.
interface sram_req_port_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] address;
  logic              write_enable;
  logic [DATA_W-1:0] write_data;
  logic              lower_byte;
  logic              upper_byte;
  logic [DATA_W-1:0] read_data;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready, read_data,
    output req_ready, rsp_valid, rsp_rdata, address, write_enable, write_data,
           lower_byte, upper_byte
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready, read_data,
    input  req_ready, rsp_valid, rsp_rdata, address, write_enable, write_data,
           lower_byte, upper_byte
  );
endinterface

// File: rtl/sram_req_port.sv
// rtl/sram_req_port.sv - single-outstanding request/response front-end for the icoboard SRAM bus
// Purpose: accepts one read or write at a time over a valid/ready handshake,
// sequences the SRAM local bus and returns read data over a response channel.
// Ports:
//   pclk    system clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     sram_req_port_if.slave (request, response and SRAM bus signals)
// All outputs are registered.
module sram_req_port #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 2,
  parameter int TURNAROUND   = 1
) (
  input  logic            pclk,
  input  logic            resetn,
  sram_req_port_if.slave  bus
);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("sram_req_port: READ_LATENCY must be 1..4");
    end
    if (TURNAROUND < 0 || TURNAROUND > 3) begin : g_bad_turnaround
      $error("sram_req_port: TURNAROUND must be 0..3");
    end
  endgenerate

  localparam logic [2:0] LAT_CNT  = 3'(READ_LATENCY);
  localparam logic [2:0] TURN_CNT = 3'(TURNAROUND);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    TURN,
    READ_WAIT,
    RESP
  } state_t;

  state_t     state;
  logic [2:0] cnt;

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      cnt              <= 3'd0;
      bus.req_ready    <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_rdata    <= '0;
      bus.address      <= '0;
      bus.write_enable <= 1'b0;
      bus.write_data   <= '0;
      bus.lower_byte   <= 1'b0;
      bus.upper_byte   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            if (bus.req_write) begin
              // An all-zero byte mask is accepted but never touches the bus:
              // staying in IDLE with req_ready low gives the one-cycle gap.
              if (bus.req_be != 2'b00) begin
                state            <= WRITE;
                bus.write_enable <= 1'b1;
                bus.lower_byte   <= bus.req_be[0];
                bus.upper_byte   <= bus.req_be[1];
                bus.address      <= bus.req_addr;
                bus.write_data   <= bus.req_wdata;
              end
            end else begin
              state          <= READ_WAIT;
              bus.address    <= bus.req_addr;
              bus.lower_byte <= 1'b1;
              bus.upper_byte <= 1'b1;
              cnt            <= 3'd1;
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end

        WRITE: begin
          bus.write_enable <= 1'b0;
          bus.lower_byte   <= 1'b0;
          bus.upper_byte   <= 1'b0;
          if (TURN_CNT == 3'd0) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
          end else begin
            state <= TURN;
            cnt   <= 3'd1;
          end
        end

        TURN: begin
          // cnt counts edges spent in TURN; leaving on the TURNAROUND-th
          // makes req_ready rise exactly TURNAROUND cycles after the pulse.
          if (cnt >= TURN_CNT) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        READ_WAIT: begin
          // cnt equals the number of edges since the address was driven.
          if (cnt >= LAT_CNT) begin
            state         <= RESP;
            bus.rsp_rdata <= bus.read_data;
            bus.rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            state          <= IDLE;
            bus.rsp_valid  <= 1'b0;
            bus.lower_byte <= 1'b0;
            bus.upper_byte <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end

        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_req_port.md
# sram_req_port

Request/response front-end for the icoboard SRAM local bus. Accepts single read/write requests from a client over a valid/ready handshake. Drives the `icoboard_sram` local-bus signals (`address`, `write_enable`, `write_data`, `lower_byte`, `upper_byte`) and returns read data over a valid/ready response channel. It sits between any client logic (CPU, DMA, UART loader) and the SRAM controller, and replaces free-running hand-sequenced bus access with a checked handshake.

## Interface

Parameters:
- `ADDR_W`, 19: word address width (1 MB SRAM, 16-bit words).
- `DATA_W`, 16: data width.
- `READ_LATENCY`, 2: cycles from address driven to `read_data` valid. Legal range 1..4; any other value is an elaboration error.
- `TURNAROUND`, 1: idle cycles forced after every write. Legal range 0..3.

Ports:
- `pclk`  in  1  system clock, all logic on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  client request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  write data.
- `req_be`  in  2  byte enables; bit0 = lower byte, bit1 = upper byte (writes only).
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  client consumes the response.
- `rsp_rdata`  out  DATA_W  read data.
- `address`  out  ADDR_W  to SRAM controller.
- `write_enable`  out  1  to SRAM controller.
- `write_data`  out  DATA_W  to SRAM controller.
- `lower_byte`  out  1  to SRAM controller, active-high.
- `upper_byte`  out  1  to SRAM controller, active-high.
- `read_data`  in  DATA_W  from SRAM controller.

## Operation

- All outputs are registered.
- Reset values: `req_ready`=0 while `resetn` is low, 1 from the first clock edge after release. `rsp_valid`=0, `rsp_rdata`=0, `address`=0, `write_enable`=0, `write_data`=0, `lower_byte`=0, `upper_byte`=0. State=IDLE.
- States:
  - IDLE: `req_ready`=1. On `req_valid`, a write goes to WRITE and a read goes to READ_WAIT.
  - WRITE: one cycle with `write_enable`=1. `lower_byte`/`upper_byte` = `req_be`. `address`/`write_data` are latched from the request. Then go to TURN, or to IDLE if `TURNAROUND`=0.
  - TURN: `write_enable`=0 and both byte lanes 0. Count `TURNAROUND` cycles, then go to IDLE.
  - READ_WAIT: `write_enable`=0, both byte lanes 1, `address` latched. A 3-bit counter runs `READ_LATENCY` cycles. On the final edge, capture `read_data` into `rsp_rdata`, set `rsp_valid`=1, and go to RESP.
  - RESP: hold `rsp_valid` and `rsp_rdata` stable until `rsp_ready`=1. On the handshake edge, clear `rsp_valid`, drop both byte lanes, and go to IDLE.
- `req_ready`=0 in every state except IDLE. Only one request is outstanding at a time.
- Write with `req_be`=2'b00: the request is accepted but no `write_enable` pulse is issued. The block goes straight to IDLE and skips TURN.
- Reads ignore `req_be` and always return the full word.
- `address` and `write_data` hold their last value when idle. `write_enable` never stays high for more than one cycle.
- Asynchronous reset at any point aborts the operation immediately. `write_enable` and `rsp_valid` drop without waiting for a clock, and a pending response is discarded.

## Timing

- Accept edge is N (`req_valid` & `req_ready` sampled high). Bus outputs update on edge N.
- Write: `write_enable`=1 during cycle [N, N+1). `req_ready` is high again in cycle [N+1+TURNAROUND, …). Minimum write period is 2+TURNAROUND cycles; 3 at default.
- Read: `read_data` is sampled at edge N+READ_LATENCY. `rsp_valid` is high from that edge on. Accept-to-response is 2 cycles at default.
- After the response handshake at edge M, `req_ready`=1 in cycle [M, M+1). The next accept is at edge M+1 at the earliest.
- `rsp_ready` held high with the response already waiting: `rsp_valid` is high for exactly 1 cycle.
- `req_*` inputs are sampled only on the accept edge. Later changes have no effect.

## Test plan

- Reset: hold `resetn`=0 for 3 cycles with `req_valid`=1 → all outputs 0 and no accept. Release → `req_ready`=1 after the first edge.
- Write then read: write 0xBEEF to 0x12345 with `req_be`=2'b11, then read 0x12345 against an SRAM model with latency 2 → exactly one `write_enable` pulse, `rsp_rdata`=0xBEEF, and `rsp_valid` 2 cycles after the read accept.
- Byte lanes: write 0xAA55 with `req_be`=2'b01 over a location holding 0x1234, then read it → 0x1255. Also check `lower_byte`=1 and `upper_byte`=0 during the write pulse.
- Back-pressure: read with `rsp_ready`=0 for 5 cycles → `rsp_valid`=1 and `rsp_rdata` constant for all 5 cycles, `req_ready`=0 throughout. Raise `rsp_ready` → `req_ready`=1 in the following cycle.
- No-op write: `req_be`=2'b00 → `write_enable` stays 0 and `req_ready` returns 1 cycle after accept.
- Reset mid-read: assert `resetn`=0 in READ_WAIT → `rsp_valid` never asserts, state returns to IDLE, and a subsequent read completes normally.
